// File: rtl/pcs_sync_acq.sv
// pcs_sync_acq: 1000BASE-X receive code-group synchronization.
// Finds commas in the 10-bit stream, establishes even/odd alignment and
// tracks a bad-code-group level to decide when sync is held or lost.
module pcs_sync_acq #(
  parameter int CG_WIDTH   = 10,
  parameter int ACQ_COMMAS = 3,
  parameter int BAD_MAX    = 4,
  parameter int GOOD_CGS   = 4
) (
  input  logic                clk,
  input  logic                mr_main_reset,
  input  logic [CG_WIDTH-1:0] rx_code_group,
  input  logic                cg_valid,
  input  logic                cg_invalid,
  input  logic                signal_detect,
  output logic                sync_status,
  output logic                rx_even,
  output logic [CG_WIDTH-1:0] rx_cg_out,
  output logic                rx_cg_valid_out,
  output logic                lost_sync
);

  localparam logic [3:0] ACQ_N  = 4'(ACQ_COMMAS);
  localparam logic [3:0] BAD_N  = 4'(BAD_MAX);
  localparam logic [3:0] GOOD_N = 4'(GOOD_CGS);

  typedef enum logic [1:0] {
    LOSS_OF_SYNC,
    COMMA_DETECT,
    ACQUIRE_SYNC,
    SYNC_ACQUIRED
  } state_t;

  state_t     state;
  logic [3:0] comma_cnt;
  logic [3:0] bad_level;
  logic [3:0] good_cnt;

  logic       comma;
  logic       cgbad;
  logic [3:0] comma_inc;
  logic [3:0] bad_inc;
  logic [3:0] good_inc;

  // Comma window is the first seven transmitted bits (a..g).
  always_comb begin
    comma     = (rx_code_group[CG_WIDTH-1 -: 7] == 7'b0011111) ||
                (rx_code_group[CG_WIDTH-1 -: 7] == 7'b1100000);
    cgbad     = cg_invalid || (comma && rx_even);
    comma_inc = comma_cnt + 4'd1;
    bad_inc   = bad_level + 4'd1;
    good_inc  = good_cnt + 4'd1;
  end

  // Synchronization FSM with registered status, alignment and data outputs.
  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state           <= LOSS_OF_SYNC;
      comma_cnt       <= '0;
      bad_level       <= '0;
      good_cnt        <= '0;
      sync_status     <= 1'b0;
      rx_even         <= 1'b0;
      rx_cg_out       <= '0;
      rx_cg_valid_out <= 1'b0;
      lost_sync       <= 1'b0;
    end else begin
      rx_cg_valid_out <= cg_valid;
      lost_sync       <= 1'b0;
      if (cg_valid) begin
        rx_cg_out <= rx_code_group;
      end

      if (!signal_detect) begin
        state       <= LOSS_OF_SYNC;
        sync_status <= 1'b0;
        lost_sync   <= (state == SYNC_ACQUIRED);
        if (cg_valid) begin
          rx_even <= ~rx_even;
        end
      end else if (cg_valid) begin
        // Plain toggle; the branches below override where alignment is forced.
        rx_even <= ~rx_even;
        case (state)
          LOSS_OF_SYNC: begin
            if (comma) begin
              comma_cnt <= 4'd1;
              rx_even   <= 1'b1;
              if (ACQ_N == 4'd1) begin
                state       <= SYNC_ACQUIRED;
                sync_status <= 1'b1;
                bad_level   <= '0;
                good_cnt    <= '0;
              end else begin
                state <= COMMA_DETECT;
              end
            end
          end

          COMMA_DETECT: begin
            if (!cg_invalid && !comma) begin
              state   <= ACQUIRE_SYNC;
              rx_even <= 1'b0;
            end else begin
              state <= LOSS_OF_SYNC;
            end
          end

          ACQUIRE_SYNC: begin
            if (cgbad) begin
              state <= LOSS_OF_SYNC;
            end else if (comma) begin
              // Not cgbad, so this comma sits in an even position.
              comma_cnt <= comma_inc;
              rx_even   <= 1'b1;
              if (comma_inc == ACQ_N) begin
                state       <= SYNC_ACQUIRED;
                sync_status <= 1'b1;
                bad_level   <= '0;
                good_cnt    <= '0;
              end else begin
                state <= COMMA_DETECT;
              end
            end
          end

          SYNC_ACQUIRED: begin
            // An even comma forces rx_even to 1, which the toggle already does.
            if (cgbad) begin
              bad_level <= bad_inc;
              good_cnt  <= '0;
              if (bad_inc == BAD_N) begin
                state       <= LOSS_OF_SYNC;
                sync_status <= 1'b0;
                lost_sync   <= 1'b1;
              end
            end else if (bad_level != '0) begin
              if (good_inc == GOOD_N) begin
                bad_level <= bad_level - 4'd1;
                good_cnt  <= '0;
              end else begin
                good_cnt <= good_inc;
              end
            end
          end

          default: begin
            state <= LOSS_OF_SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcs_sync_acq.sv
// Directed self-checking bench for pcs_sync_acq (default and short-threshold builds).
module tb_pcs_sync_acq;

  localparam logic [9:0] K28_5N = 10'b0011111010;
  localparam logic [9:0] K28_5P = 10'b1100000101;
  localparam logic [9:0] D5_6   = 10'b1010010110;

  logic       clk = 1'b0;
  logic       mr_main_reset = 1'b0;
  logic [9:0] rx_code_group = '0;
  logic       cg_valid = 1'b0;
  logic       cg_invalid = 1'b0;
  logic       signal_detect = 1'b1;

  logic       sync_status, rx_even, rx_cg_valid_out, lost_sync;
  logic [9:0] rx_cg_out;
  logic       sync_status2, rx_even2, rx_cg_valid_out2, lost_sync2;
  logic [9:0] rx_cg_out2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pcs_sync_acq dut (
    .clk(clk), .mr_main_reset(mr_main_reset), .rx_code_group(rx_code_group),
    .cg_valid(cg_valid), .cg_invalid(cg_invalid), .signal_detect(signal_detect),
    .sync_status(sync_status), .rx_even(rx_even), .rx_cg_out(rx_cg_out),
    .rx_cg_valid_out(rx_cg_valid_out), .lost_sync(lost_sync)
  );

  pcs_sync_acq #(.CG_WIDTH(10), .ACQ_COMMAS(1), .BAD_MAX(2), .GOOD_CGS(4)) dut2 (
    .clk(clk), .mr_main_reset(mr_main_reset), .rx_code_group(rx_code_group),
    .cg_valid(cg_valid), .cg_invalid(cg_invalid), .signal_detect(signal_detect),
    .sync_status(sync_status2), .rx_even(rx_even2), .rx_cg_out(rx_cg_out2),
    .rx_cg_valid_out(rx_cg_valid_out2), .lost_sync(lost_sync2)
  );

  task automatic do_reset();
    mr_main_reset = 1'b0;
    cg_valid = 1'b0;
    cg_invalid = 1'b0;
    signal_detect = 1'b1;
    rx_code_group = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mr_main_reset = 1'b1;
  endtask

  // Apply one cycle of input, then sample 1 time unit after the edge.
  task automatic step(input logic [9:0] cg, input logic v, input logic inv, input logic sd);
    rx_code_group = cg;
    cg_valid = v;
    cg_invalid = inv;
    signal_detect = sd;
    @(posedge clk); #1;
  endtask

  task automatic sync_up();
    do_reset();
    for (int i = 0; i < 6; i++) step((i % 2 == 0) ? K28_5N : D5_6, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    mr_main_reset = 1'b0;
    #3;
    checks++; if (sync_status !== 1'b0) begin errors++; $display("FAIL reset_sync got %b want 0", sync_status); end
    checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL reset_rx_even got %b want 0", rx_even); end
    checks++; if (rx_cg_out !== 10'h000) begin errors++; $display("FAIL reset_cg_out got %h want 000", rx_cg_out); end
    checks++; if (rx_cg_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b want 0", rx_cg_valid_out); end
    checks++; if (lost_sync !== 1'b0) begin errors++; $display("FAIL reset_lost got %b want 0", lost_sync); end
    checks++; if (dut.bad_level !== 4'd0) begin errors++; $display("FAIL reset_bad_level got %0d want 0", dut.bad_level); end
  endtask

  task automatic test_acquire();
    logic [9:0] cg;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cg = (i % 2 == 0) ? K28_5N : D5_6;
      step(cg, 1'b1, 1'b0, 1'b1);
      checks++; if (rx_even !== (i % 2 == 0)) begin errors++; $display("FAIL acq_rx_even[%0d] got %b want %b", i, rx_even, (i % 2 == 0)); end
      checks++; if (sync_status !== (i >= 4)) begin errors++; $display("FAIL acq_sync[%0d] got %b want %b", i, sync_status, (i >= 4)); end
      checks++; if (lost_sync !== 1'b0) begin errors++; $display("FAIL acq_lost[%0d] got %b want 0", i, lost_sync); end
      checks++; if (rx_cg_out !== cg || rx_cg_valid_out !== 1'b1) begin errors++; $display("FAIL acq_cg_out[%0d] got %h/%b want %h/1", i, rx_cg_out, rx_cg_valid_out, cg); end
    end
  endtask

  task automatic test_bad_loss();
    sync_up();
    for (int i = 0; i < 4; i++) begin
      step(D5_6, 1'b1, 1'b1, 1'b1);
      checks++; if (dut.bad_level !== 4'(i + 1)) begin errors++; $display("FAIL loss_bad_level[%0d] got %0d want %0d", i, dut.bad_level, i + 1); end
      checks++; if (sync_status !== (i < 3)) begin errors++; $display("FAIL loss_sync[%0d] got %b want %b", i, sync_status, (i < 3)); end
      checks++; if (lost_sync !== (i == 3)) begin errors++; $display("FAIL loss_pulse[%0d] got %b want %b", i, lost_sync, (i == 3)); end
    end
    step(D5_6, 1'b1, 1'b0, 1'b1);
    checks++; if (lost_sync !== 1'b0) begin errors++; $display("FAIL loss_pulse_width got %b want 0", lost_sync); end
  endtask

  task automatic test_recover();
    sync_up();
    for (int i = 0; i < 3; i++) step(D5_6, 1'b1, 1'b1, 1'b1);
    checks++; if (dut.bad_level !== 4'd3) begin errors++; $display("FAIL rec_bad3 got %0d want 3", dut.bad_level); end
    for (int i = 1; i <= 12; i++) begin
      step(D5_6, 1'b1, 1'b0, 1'b1);
      checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL rec_sync[%0d] got %b want 1", i, sync_status); end
      if (i % 4 == 0) begin
        checks++; if (dut.bad_level !== 4'(3 - i / 4)) begin errors++; $display("FAIL rec_bad_level[%0d] got %0d want %0d", i, dut.bad_level, 3 - i / 4); end
      end
    end
    for (int i = 0; i < 3; i++) step(D5_6, 1'b1, 1'b1, 1'b1);
    checks++; if (dut.bad_level !== 4'd3 || sync_status !== 1'b1) begin errors++; $display("FAIL rec_rebad got %0d/%b want 3/1", dut.bad_level, sync_status); end
  endtask

  task automatic test_odd_comma();
    sync_up();
    step(D5_6, 1'b1, 1'b0, 1'b1);
    checks++; if (rx_even !== 1'b1) begin errors++; $display("FAIL odd_pre_even got %b want 1", rx_even); end
    step(K28_5P, 1'b1, 1'b0, 1'b1);
    checks++; if (dut.bad_level !== 4'd1) begin errors++; $display("FAIL odd_bad_level got %0d want 1", dut.bad_level); end
    checks++; if (rx_even !== 1'b0) begin errors++; $display("FAIL odd_rx_even got %b want 0", rx_even); end
    checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL odd_sync got %b want 1", sync_status); end
  endtask

  task automatic test_signal_drop();
    sync_up();
    step(D5_6, 1'b0, 1'b0, 1'b0);
    checks++; if (sync_status !== 1'b0 || lost_sync !== 1'b1) begin errors++; $display("FAIL drop_edge got sync=%b lost=%b want 0/1", sync_status, lost_sync); end
    step(D5_6, 1'b0, 1'b0, 1'b1);
    checks++; if (lost_sync !== 1'b0) begin errors++; $display("FAIL drop_pulse_width got %b want 0", lost_sync); end
    step(K28_5N, 1'b1, 1'b0, 1'b1);
    checks++; if (dut.comma_cnt !== 4'd1 || rx_even !== 1'b1 || sync_status !== 1'b0) begin errors++; $display("FAIL drop_recomma got cnt=%0d even=%b sync=%b want 1/1/0", dut.comma_cnt, rx_even, sync_status); end
    step(D5_6, 1'b1, 1'b0, 1'b1);
    step(K28_5N, 1'b1, 1'b0, 1'b1);
    checks++; if (dut.comma_cnt !== 4'd2 || sync_status !== 1'b0) begin errors++; $display("FAIL drop_second_comma got cnt=%0d sync=%b want 2/0", dut.comma_cnt, sync_status); end
  endtask

  task automatic test_gaps();
    do_reset();
    step(K28_5N, 1'b1, 1'b0, 1'b1);
    step(D5_6, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(K28_5N, 1'b0, 1'b0, 1'b1);
      checks++; if (dut.comma_cnt !== 4'd1 || rx_even !== 1'b0) begin errors++; $display("FAIL gap_hold[%0d] got cnt=%0d even=%b want 1/0", i, dut.comma_cnt, rx_even); end
      checks++; if (rx_cg_valid_out !== 1'b0 || rx_cg_out !== D5_6) begin errors++; $display("FAIL gap_out[%0d] got %b/%h want 0/%h", i, rx_cg_valid_out, rx_cg_out, D5_6); end
    end
    step(K28_5N, 1'b1, 1'b0, 1'b1);
    checks++; if (dut.comma_cnt !== 4'd2 || rx_even !== 1'b1) begin errors++; $display("FAIL gap_resume got cnt=%0d even=%b want 2/1", dut.comma_cnt, rx_even); end
    step(D5_6, 1'b1, 1'b0, 1'b1);
    step(K28_5N, 1'b1, 1'b0, 1'b1);
    checks++; if (sync_status !== 1'b1) begin errors++; $display("FAIL gap_sync got %b want 1", sync_status); end
  endtask

  task automatic test_short_params();
    do_reset();
    step(K28_5N, 1'b1, 1'b0, 1'b1);
    checks++; if (sync_status2 !== 1'b1 || rx_even2 !== 1'b1) begin errors++; $display("FAIL short_sync got sync=%b even=%b want 1/1", sync_status2, rx_even2); end
    step(D5_6, 1'b1, 1'b0, 1'b1);
    step(D5_6, 1'b1, 1'b1, 1'b1);
    checks++; if (sync_status2 !== 1'b1 || dut2.bad_level !== 4'd1) begin errors++; $display("FAIL short_bad1 got sync=%b bad=%0d want 1/1", sync_status2, dut2.bad_level); end
    step(D5_6, 1'b1, 1'b1, 1'b1);
    checks++; if (sync_status2 !== 1'b0 || lost_sync2 !== 1'b1) begin errors++; $display("FAIL short_loss got sync=%b lost=%b want 0/1", sync_status2, lost_sync2); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_bad_loss();
    test_recover();
    test_odd_comma();
    test_signal_drop();
    test_gaps();
    test_short_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcs_sync_acq.md
# pcs_sync_acq

Parametrised receive code-group synchronization block for the 1000BASE-X PCS receive path, the successor to the fixed-threshold synchronization logic inside `pcs`. It sits between the PMA deserializer and the 8B/10B decoder. It searches the 10-bit stream for commas, establishes even/odd code-group alignment, and reports `sync_status`. Acquisition, loss and recovery thresholds are parameters rather than fixed states, and the block adds a loss-of-sync event pulse and a pipelined, qualified code-group output.

## Interface
- `CG_WIDTH`, 10: code-group width. Must be 10; the comma window is bits [9:3], with bit 9 = 'a', the first transmitted bit.
- `ACQ_COMMAS`, 3: number of aligned commas needed to reach sync. Range 1..15.
- `BAD_MAX`, 4: bad-code-group level at which sync is lost. Range 1..15.
- `GOOD_CGS`, 4: consecutive good code groups that lower the bad level by one. Range 1..15.
- `clk` in 1: receive clock, rising edge.
- `mr_main_reset` in 1: asynchronous, active-low reset; asserted when 0.
- `rx_code_group` in `CG_WIDTH`: code group from the PMA.
- `cg_valid` in 1: `rx_code_group` is valid this cycle.
- `cg_invalid` in 1: the decoder flags this code group as not in the 8B/10B table or as having a disparity error; qualified by `cg_valid`.
- `signal_detect` in 1: PMA signal present.
- `sync_status` out 1: 1 = synchronized (OK).
- `rx_even` out 1: the code group on `rx_cg_out` is in an even position.
- `rx_cg_out` out `CG_WIDTH`: registered copy of the accepted code group.
- `rx_cg_valid_out` out 1: `rx_cg_out` is valid.
- `lost_sync` out 1: one-cycle pulse on any transition out of SYNC_ACQUIRED.

## Operation
- comma = `rx_code_group[9:3]` equals 0011111 or 1100000.
- cgbad = `cg_invalid` OR (comma AND the current `rx_even` = 1), i.e. a comma landing in an odd position.
- cggood = NOT cgbad.
- `rx_even` toggles on every valid code group, except where a rule below forces it.
- States: LOSS_OF_SYNC, COMMA_DETECT, ACQUIRE_SYNC, SYNC_ACQUIRED. Counters: `comma_cnt`, `bad_level`, `good_cnt`, each 4 bits.
- State advances only on cycles with `cg_valid` = 1. With `cg_valid` = 0, state, counters and `rx_even` hold.
- `signal_detect` = 0 forces LOSS_OF_SYNC at the next edge from any state, regardless of `cg_valid`. This has priority over all other rules.
- LOSS_OF_SYNC:
  - `sync_status` = 0.
  - On comma: go to COMMA_DETECT, set `comma_cnt` = 1, force `rx_even` = 1.
- COMMA_DETECT:
  - Next code group with `cg_invalid` = 0 and not a comma: go to ACQUIRE_SYNC, `rx_even` = 0.
  - Anything else: go to LOSS_OF_SYNC.
- ACQUIRE_SYNC:
  - cgbad: go to LOSS_OF_SYNC.
  - Comma with `rx_even` = 0: increment `comma_cnt`, force `rx_even` = 1.
    - If the new count equals `ACQ_COMMAS`: go to SYNC_ACQUIRED, set `bad_level` = 0 and `good_cnt` = 0.
    - Otherwise: go to COMMA_DETECT.
  - Any other code group: stay.
- `ACQ_COMMAS` = 1: the first comma in LOSS_OF_SYNC goes directly to SYNC_ACQUIRED.
- SYNC_ACQUIRED, `sync_status` = 1:
  - cgbad: increment `bad_level` and clear `good_cnt`. When `bad_level` reaches `BAD_MAX`, go to LOSS_OF_SYNC and pulse `lost_sync`.
  - cggood with `bad_level` > 0: increment `good_cnt`. When it reaches `GOOD_CGS`, decrement `bad_level` and clear `good_cnt`.
  - cggood with `bad_level` = 0: `good_cnt` stays 0.
  - A comma in an even position (current `rx_even` = 0) resets `rx_even` to 1; it is cggood.
- `lost_sync` also pulses when `signal_detect` drop ends SYNC_ACQUIRED.

## Timing
- Reset values (asynchronous, on `mr_main_reset` = 0): state LOSS_OF_SYNC; all counters 0; `sync_status`, `rx_even`, `rx_cg_out`, `rx_cg_valid_out` and `lost_sync` all 0.
- Latency is 1 cycle. `rx_cg_out`, `rx_cg_valid_out` and `rx_even` appear at the edge that samples the input.
- `sync_status` reflects the state after that same edge.
- `sync_status` rises at the edge sampling the `ACQ_COMMAS`-th aligned comma and falls at the edge sampling the final bad code group.
- `lost_sync` is high for exactly one cycle, aligned with `sync_status` falling.
- Release of reset mid-stream: the first valid code group after release is evaluated in LOSS_OF_SYNC.

## Test plan
- Reset, then K28.5 0011111010 followed by D5.6 1010010110, repeated 3 pairs with `cg_valid` = 1 and `signal_detect` = 1:
  - `sync_status` rises at the edge of the 3rd comma.
  - `rx_even` alternates 1,0,1,0 from the first comma.
  - `lost_sync` stays 0.
- Synced, then 4 code groups with `cg_invalid` = 1: `bad_level` goes 1..4; `sync_status` falls and `lost_sync` pulses at the edge of the 4th bad code group.
- Synced, 3 bad code groups, then 12 good code groups, then 3 bad: `bad_level` returns to 0 after 12 good, and sync is kept throughout.
- Synced, K28.5 1100000101 in an odd position: counts as bad (`bad_level` = 1), `rx_even` still toggles.
- `signal_detect` dropped for 1 cycle while `cg_valid` = 0 during SYNC_ACQUIRED: `sync_status` falls at the next edge, `lost_sync` pulses, and the next comma enters COMMA_DETECT.
- With `ACQ_COMMAS` = 1 and `BAD_MAX` = 2: a single comma syncs; 2 bad code groups lose sync. Also drive `cg_valid` = 0 gaps mid-acquisition and check that state holds.
